// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path.
// Byte constants are in shift-register order: first bit on the wire ends up in [7].
package usb_rx_pkg;

    typedef enum logic {
        DEC_IDLE,
        DEC_RUN
    } dec_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h01;

    localparam logic [7:0] PID_ACK   = 8'h4B;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_OUT   = 8'h87;
    localparam logic [7:0] PID_IN    = 8'h96;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'hD2;

    // Consecutive decoded ones after which the next bit is a stuffed bit.
    localparam int unsigned STUFF_RUN = 6;

endpackage

// File: rtl/rcv_bit_decoder_if.sv
// Line inputs and decoded outputs between the synchronizers, bit decoder and receive control unit.
interface rcv_bit_decoder_if;

    logic       d_plus_sync;
    logic       d_minus_sync;
    logic       edge_sig;
    logic       packet_done;
    logic       eop;
    logic       byte_finish;
    logic [7:0] rx_shift_register;

    modport master (
        input  d_plus_sync,
        input  d_minus_sync,
        output edge_sig,
        output packet_done,
        output eop,
        output byte_finish,
        output rx_shift_register
    );

    modport slave (
        output d_plus_sync,
        output d_minus_sync,
        input  edge_sig,
        input  packet_done,
        input  eop,
        input  byte_finish,
        input  rx_shift_register
    );

endinterface

// File: rtl/rcv_bit_timer.sv
// Bit-period counter with edge resync; raises sample for one cycle per bit period while running.
module rcv_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned SAMPLE_PT    = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic run,
    input  logic d_edge,
    output logic sample
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_PT);
    localparam logic [CW-1:0] CNT_RESYNC = CW'(1);

    logic [CW-1:0] counter_q;
    logic [CW-1:0] counter_d;

    // An edge while idle is the J->K start edge, so it also seeds the count for entry.
    always_comb begin
        counter_d = '0;
        if (d_edge) begin
            counter_d = CNT_RESYNC;
        end else if (run) begin
            counter_d = (counter_q == CNT_LAST) ? '0 : counter_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_d;
        end
    end

    assign sample = run && (counter_q == CNT_SAMPLE);

endmodule

// File: rtl/rcv_bit_decoder.sv
// USB receive front end: bit timing recovery, NRZI decode, bit unstuffing and byte assembly.
module rcv_bit_decoder
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned SAMPLE_PT    = 3
) (
    input  logic              clk,
    input  logic              n_rst,
    rcv_bit_decoder_if.master bus
);

    dec_state_t state_q, state_d;

    logic       d_prev_q, d_prev_d;
    logic       nrzi_ref_q, nrzi_ref_d;
    logic [2:0] ones_cnt_q, ones_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_register_q, rx_shift_register_d;
    logic       edge_sig_q, edge_sig_d;
    logic       packet_done_q, packet_done_d;
    logic       eop_q, eop_d;
    logic       byte_finish_q, byte_finish_d;

    logic d_edge;
    logic sample;
    logic run;
    logic line_se0;
    logic line_j;
    logic bit_val;

    assign d_edge   = bus.d_plus_sync != d_prev_q;
    assign run      = state_q == DEC_RUN;
    assign line_se0 = !bus.d_plus_sync && !bus.d_minus_sync;
    assign line_j   = bus.d_plus_sync && !bus.d_minus_sync;
    assign bit_val  = bus.d_plus_sync == nrzi_ref_q;

    rcv_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_PT    (SAMPLE_PT)
    ) u_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .run    (run),
        .d_edge (d_edge),
        .sample (sample)
    );

    always_comb begin
        state_d             = state_q;
        d_prev_d            = bus.d_plus_sync;
        nrzi_ref_d          = nrzi_ref_q;
        ones_cnt_d          = ones_cnt_q;
        bit_cnt_d           = bit_cnt_q;
        rx_shift_register_d = rx_shift_register_q;
        edge_sig_d          = d_edge;
        packet_done_d       = 1'b0;
        eop_d               = eop_q;
        byte_finish_d       = 1'b0;

        unique case (state_q)
            DEC_IDLE: begin
                if (d_edge && !bus.d_plus_sync) begin
                    state_d    = DEC_RUN;
                    bit_cnt_d  = '0;
                    ones_cnt_d = '0;
                end
            end
            DEC_RUN: begin
                if (sample) begin
                    packet_done_d = 1'b1;
                    if (line_se0) begin
                        eop_d      = 1'b1;
                        nrzi_ref_d = 1'b1;
                        bit_cnt_d  = '0;
                        ones_cnt_d = '0;
                    end else begin
                        eop_d      = 1'b0;
                        nrzi_ref_d = bus.d_plus_sync;
                        // eop_q doubles as "previous sample was SE0": J after SE0 ends the packet.
                        if (eop_q && line_j) begin
                            state_d = DEC_IDLE;
                        end else if (ones_cnt_q == 3'(STUFF_RUN)) begin
                            ones_cnt_d = '0;
                        end else begin
                            rx_shift_register_d = {rx_shift_register_q[6:0], bit_val};
                            bit_cnt_d           = bit_cnt_q + 3'd1;
                            byte_finish_d       = bit_cnt_q == 3'd7;
                            ones_cnt_d          = bit_val ? ones_cnt_q + 3'd1 : '0;
                        end
                    end
                end
            end
            default: state_d = DEC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q             <= DEC_IDLE;
            d_prev_q            <= 1'b1;
            nrzi_ref_q          <= 1'b1;
            ones_cnt_q          <= '0;
            bit_cnt_q           <= '0;
            rx_shift_register_q <= '0;
            edge_sig_q          <= 1'b0;
            packet_done_q       <= 1'b0;
            eop_q               <= 1'b0;
            byte_finish_q       <= 1'b0;
        end else begin
            state_q             <= state_d;
            d_prev_q            <= d_prev_d;
            nrzi_ref_q          <= nrzi_ref_d;
            ones_cnt_q          <= ones_cnt_d;
            bit_cnt_q           <= bit_cnt_d;
            rx_shift_register_q <= rx_shift_register_d;
            edge_sig_q          <= edge_sig_d;
            packet_done_q       <= packet_done_d;
            eop_q               <= eop_d;
            byte_finish_q       <= byte_finish_d;
        end
    end

    assign bus.edge_sig          = edge_sig_q;
    assign bus.packet_done       = packet_done_q;
    assign bus.eop               = eop_q;
    assign bus.byte_finish       = byte_finish_q;
    assign bus.rx_shift_register = rx_shift_register_q;

endmodule

// File: tb/tb_rcv_bit_decoder.sv
// Bench for rcv_bit_decoder: encodes byte streams onto the line (NRZI + stuffing) and checks decoded results.
module tb_rcv_bit_decoder;
    import usb_rx_pkg::*;

    localparam int unsigned CPB = 8;
    localparam int SYM_K   = 0;
    localparam int SYM_J   = 1;
    localparam int SYM_SE0 = 2;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    rcv_bit_decoder_if bus ();

    rcv_bit_decoder #(
        .CLKS_PER_BIT (CPB),
        .SAMPLE_PT    (3)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {bus.edge_sig, bus.packet_done, bus.eop, bus.byte_finish, bus.rx_shift_register};
    endfunction

    // Monitor: logs every strobe observed on the falling edge.
    int         cyc = 0;
    int         pd_total = 0;
    int         bf_total = 0;
    int         edge_total = 0;
    logic       eop_log [0:4095];
    logic [7:0] byte_log [0:1023];
    int         bf_pd_log [0:1023];
    int         edge_cyc_log [0:4095];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (n_rst) begin
            if (bus.packet_done) begin
                eop_log[pd_total] <= bus.eop;
                pd_total          <= pd_total + 1;
            end
            if (bus.byte_finish) begin
                byte_log[bf_total]  <= bus.rx_shift_register;
                bf_pd_log[bf_total] <= pd_total + (bus.packet_done ? 1 : 0);
                bf_total            <= bf_total + 1;
            end
            if (bus.edge_sig) begin
                edge_cyc_log[edge_total] <= cyc;
                edge_total               <= edge_total + 1;
            end
        end
    end

    // Reference encoder: sync + payload -> line symbols, with expected bytes and their strobe positions.
    logic [7:0] pay_q[$];
    logic [7:0] exp_bytes[$];
    int         exp_bf_pos[$];
    int         sym_q[$];
    int         len_q[$];
    int         exp_edges;

    task automatic build_line();
        int level;
        int ones;
        int prev_dp;
        logic b;
        sym_q.delete();
        len_q.delete();
        exp_bytes.delete();
        exp_bf_pos.delete();
        exp_bytes.push_back(SYNC_BYTE);
        foreach (pay_q[k]) exp_bytes.push_back(pay_q[k]);
        level = SYM_J;
        ones  = 0;
        foreach (exp_bytes[k]) begin
            for (int i = 7; i >= 0; i--) begin
                b = exp_bytes[k][i];
                if (!b) level = (level == SYM_J) ? SYM_K : SYM_J;
                sym_q.push_back(level);
                if (i == 0) exp_bf_pos.push_back(sym_q.size());
                ones = b ? ones + 1 : 0;
                if (ones == 6) begin
                    level = (level == SYM_J) ? SYM_K : SYM_J;
                    sym_q.push_back(level);
                    ones = 0;
                end
            end
        end
        sym_q.push_back(SYM_SE0);
        sym_q.push_back(SYM_SE0);
        sym_q.push_back(SYM_J);
        foreach (sym_q[k]) len_q.push_back(CPB);
        exp_edges = 0;
        prev_dp   = 1;
        foreach (sym_q[k]) begin
            if ((sym_q[k] == SYM_J ? 1 : 0) != prev_dp) exp_edges++;
            prev_dp = (sym_q[k] == SYM_J) ? 1 : 0;
        end
    endtask

    int k_cyc;

    task automatic drive_syms(input int count);
        for (int s = 0; s < count; s++) begin
            if (s == 0) k_cyc = cyc;
            bus.d_plus_sync  = (sym_q[s] == SYM_J);
            bus.d_minus_sync = (sym_q[s] == SYM_K);
            repeat (len_q[s]) @(negedge clk);
        end
    endtask

    task automatic run_packet(input string name, input bit jitter);
        int p0, b0, e0, nsym, i, j;
        build_line();
        nsym = sym_q.size();
        if (jitter && pay_q.size() > 0) begin
            i = $urandom_range(8, nsym - 5);
            j = $urandom_range(8, nsym - 5);
            len_q[i] = CPB - 1;
            if (j != i) len_q[j] = CPB + 1;
        end
        p0 = pd_total;
        b0 = bf_total;
        e0 = edge_total;
        drive_syms(nsym);
        repeat (4) @(negedge clk);
        check({name, "_strobes"}, pd_total - p0, nsym);
        check({name, "_nbytes"}, bf_total - b0, exp_bytes.size());
        foreach (exp_bytes[k]) begin
            check({name, "_byte"}, byte_log[b0 + k], exp_bytes[k]);
            check({name, "_bf_pos"}, bf_pd_log[b0 + k] - p0, exp_bf_pos[k]);
        end
        check({name, "_eop_data"}, eop_log[p0 + nsym - 4], 0);
        check({name, "_eop_se0a"}, eop_log[p0 + nsym - 3], 1);
        check({name, "_eop_se0b"}, eop_log[p0 + nsym - 2], 1);
        check({name, "_eop_j"}, eop_log[p0 + nsym - 1], 0);
        check({name, "_edges"}, edge_total - e0, exp_edges);
        check({name, "_edge_lat"}, edge_cyc_log[e0], k_cyc + 1);
    endtask

    logic [15:0] win;

    initial begin
        n_rst            = 1'b0;
        bus.d_plus_sync  = 1'b1;
        bus.d_minus_sync = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs", outs(), 0);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_outs", outs(), 0);
        check("idle_strobes", pd_total, 0);
        check("idle_edges", edge_total, 0);

        pay_q.delete();
        run_packet("sync", 1'b0);
        pay_q = {PID_ACK};
        run_packet("ack", 1'b0);
        pay_q = {PID_DATA1};
        run_packet("data1", 1'b0);
        pay_q = {8'hFF};
        run_packet("stuff", 1'b0);
        pay_q = {PID_DATA0, 8'hFF, 8'hFE};
        run_packet("stuff2", 1'b1);

        for (int r = 0; r < 10; r++) begin
            int n;
            pay_q.delete();
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) pay_q.push_back(8'($urandom_range(0, 255)));
            run_packet(r >= 4 ? "rand_jit" : "rand", r >= 4);
        end

        // Reset in the middle of the PID byte.
        pay_q = {PID_OUT, 8'hA5};
        build_line();
        drive_syms(13);
        win = {SYNC_BYTE, PID_OUT};
        check("pre_rst_rx", bus.rx_shift_register, win[10:3]);
        #2 n_rst = 1'b0;
        #1 check("mid_rst_outs", outs(), 0);
        bus.d_plus_sync  = 1'b1;
        bus.d_minus_sync = 1'b0;
        repeat (3) @(negedge clk);
        check("held_rst_outs", outs(), 0);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_outs", outs(), 0);

        pay_q = {PID_NAK, PID_IN};
        run_packet("post_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
